// File: rtl/lgn_frame_loader.sv
// Host-side frame loader: replays a pixel byte stream onto the chip's strobed
// pixel bus, waits out the settle latency, then returns the captured score.
module lgn_frame_loader #(
    parameter int unsigned WORDS   = 98,
    parameter int unsigned BUS_W   = 8,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned FRAME_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [BUS_W-1:0]   s_data,
    output logic [BUS_W-1:0]   pix_out,
    output logic               we_n,
    input  logic [OUT_W-1:0]   res_in,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [OUT_W-1:0]   m_data,
    output logic               busy,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int unsigned CNT_W = ($clog2(WORDS) > 7) ? $clog2(WORDS) : 7;
    localparam logic [CNT_W-1:0]   LAST_WORD   = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [7:0]         SETTLE_INIT = 8'(LATENCY);
    localparam logic [FRAME_W-1:0] FRAME_ONE   = FRAME_W'(1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_RESULT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] word_cnt, word_cnt_nxt;
    logic [7:0]       settle_cnt, settle_cnt_nxt;
    logic             accept, capture, handshake;

    assign s_ready = (state == ST_LOAD);
    assign m_valid = (state == ST_RESULT);
    assign busy    = (state != ST_LOAD) || (word_cnt != '0);

    // flush overrides any accept or result handshake on the same edge
    always_comb begin
        state_nxt      = state;
        word_cnt_nxt   = word_cnt;
        settle_cnt_nxt = settle_cnt;
        accept         = 1'b0;
        capture        = 1'b0;
        handshake      = 1'b0;
        if (flush) begin
            state_nxt    = ST_LOAD;
            word_cnt_nxt = '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (s_valid) begin
                        accept = 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            state_nxt      = ST_SETTLE;
                            word_cnt_nxt   = '0;
                            settle_cnt_nxt = SETTLE_INIT;
                        end else begin
                            word_cnt_nxt = word_cnt + CNT_ONE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        capture   = 1'b1;
                        state_nxt = ST_RESULT;
                    end else begin
                        settle_cnt_nxt = settle_cnt - 8'd1;
                    end
                end
                ST_RESULT: begin
                    if (m_ready) begin
                        handshake = 1'b1;
                        state_nxt = ST_LOAD;
                    end
                end
                default: state_nxt = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_LOAD;
            word_cnt   <= '0;
            settle_cnt <= '0;
            pix_out    <= '0;
            we_n       <= 1'b1;
            m_data     <= '0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            word_cnt   <= word_cnt_nxt;
            settle_cnt <= settle_cnt_nxt;
            we_n       <= !accept;
            if (accept)    pix_out   <= s_data;
            if (capture)   m_data    <= res_in;
            if (handshake) frame_cnt <= frame_cnt + FRAME_ONE;
        end
    end

endmodule

// File: tb/tb_lgn_frame_loader.sv
// Randomized self-checking bench for lgn_frame_loader against a timing-rule
// reference model (expected pixels, capture edge, frame count).
module tb_lgn_frame_loader;

    localparam int unsigned WORDS   = 98;
    localparam int unsigned BUS_W   = 8;
    localparam int unsigned OUT_W   = 16;
    localparam int unsigned LATENCY = 4;
    localparam int unsigned FRAME_W = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic               s_valid;
    logic               s_ready;
    logic [BUS_W-1:0]   s_data;
    logic [BUS_W-1:0]   pix_out;
    logic               we_n;
    logic [OUT_W-1:0]   res_in;
    logic               m_valid;
    logic               m_ready;
    logic [OUT_W-1:0]   m_data;
    logic               busy;
    logic [FRAME_W-1:0] frame_cnt;

    lgn_frame_loader #(
        .WORDS   (WORDS),
        .BUS_W   (BUS_W),
        .OUT_W   (OUT_W),
        .LATENCY (LATENCY),
        .FRAME_W (FRAME_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .pix_out   (pix_out),
        .we_n      (we_n),
        .res_in    (res_in),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned strobe_cnt = 0;

    // reference model state
    logic [BUS_W-1:0] exp_pix = '0;
    logic [OUT_W-1:0] exp_res = '0;
    int unsigned      exp_frames = 0;

    always @(negedge clk) if (rst_n && !we_n) strobe_cnt++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt();
        return 32'(exp_frames % (1 << FRAME_W));
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_pix"},   32'(pix_out),   32'h0);
        check_val({tag, "_we_n"},  32'(we_n),      32'h1);
        check_val({tag, "_mval"},  32'(m_valid),   32'h0);
        check_val({tag, "_mdata"}, 32'(m_data),    32'h0);
        check_val({tag, "_fcnt"},  32'(frame_cnt), 32'h0);
        check_val({tag, "_busy"},  32'(busy),      32'h0);
        check_val({tag, "_srdy"},  32'(s_ready),   32'h1);
    endtask

    // offer n words; with gaps, s_valid alternates every cycle
    task automatic load_words(input int unsigned n, input bit gaps);
        int unsigned k = 0;
        bit tog = 1'($urandom);
        while (k < n) begin
            s_valid = gaps ? tog : 1'b1;
            tog = ~tog;
            s_data = BUS_W'($urandom);
            check_val("s_ready_load", 32'(s_ready), 32'h1);
            tick();
            if (s_valid) begin
                exp_pix = s_data;
                k++;
                check_val("we_n_accept", 32'(we_n), 32'h0);
            end else begin
                check_val("we_n_gap", 32'(we_n), 32'h1);
            end
            check_val("pix_out", 32'(pix_out), 32'(exp_pix));
            check_val("busy_load", 32'(busy), 32'(k != 0));
        end
        s_valid = 1'b0;
    endtask

    // called right after the last accept edge t_L; capture is at t_L+1+LATENCY
    task automatic finish_frame(input int unsigned bp_cycles, input bit flush_result);
        check_val("s_ready_after_last", 32'(s_ready), 32'h0);
        m_ready = (bp_cycles == 0) && !flush_result;
        repeat (LATENCY + 1) begin
            check_val("m_valid_early", 32'(m_valid), 32'h0);
            check_val("busy_settle", 32'(busy), 32'h1);
            res_in = OUT_W'($urandom);
            exp_res = res_in;
            tick();
            check_val("we_n_settle", 32'(we_n), 32'h1);
        end
        check_val("m_valid_capture", 32'(m_valid), 32'h1);
        check_val("m_data_capture", 32'(m_data), 32'(exp_res));
        repeat (bp_cycles) begin
            res_in = OUT_W'($urandom);
            tick();
            check_val("m_valid_hold", 32'(m_valid), 32'h1);
            check_val("m_data_hold", 32'(m_data), 32'(exp_res));
            check_val("s_ready_hold", 32'(s_ready), 32'h0);
        end
        m_ready = 1'b1;
        flush = flush_result;
        tick();
        if (!flush_result) exp_frames++;
        flush = 1'b0;
        m_ready = 1'b0;
        check_val("m_valid_done", 32'(m_valid), 32'h0);
        check_val("s_ready_done", 32'(s_ready), 32'h1);
        check_val("busy_done", 32'(busy), 32'h0);
        check_val("frame_cnt", 32'(frame_cnt), exp_cnt());
        check_val("m_data_kept", 32'(m_data), 32'(exp_res));
    endtask

    task automatic full_frame(input bit gaps, input int unsigned bp_cycles);
        int unsigned s0 = strobe_cnt;
        load_words(WORDS, gaps);
        finish_frame(bp_cycles, 1'b0);
        check_val("strobe_count", 32'(strobe_cnt - s0), 32'(WORDS));
    endtask

    initial begin
        logic [31:0] wrap_exp [5];
        wrap_exp = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
        rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0;
        m_ready = 1'b0; res_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        full_frame(1'b0, 0);
        full_frame(1'b1, 0);
        full_frame(1'b0, 20);

        // flush mid-frame with a word offered on the flush edge
        load_words(40, 1'b0);
        s_valid = 1'b1;
        s_data = BUS_W'($urandom);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        s_valid = 1'b0;
        check_val("flush_we_n", 32'(we_n), 32'h1);
        check_val("flush_pix", 32'(pix_out), 32'(exp_pix));
        check_val("flush_busy", 32'(busy), 32'h0);
        check_val("flush_srdy", 32'(s_ready), 32'h1);
        check_val("flush_fcnt", 32'(frame_cnt), exp_cnt());
        full_frame(1'b1, 3);

        // flush while a result is being handshaken
        load_words(WORDS, 1'b0);
        finish_frame(2, 1'b1);

        // reset while a strobe is active
        load_words(10, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_load");
        #2 rst_n = 1'b1;
        exp_pix = '0; exp_frames = 0;

        // reset during settle
        tick();
        load_words(WORDS, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_settle");
        #2 rst_n = 1'b1;
        m_ready = 1'b1;
        repeat (10) begin
            tick();
            check_val("no_m_valid", 32'(m_valid), 32'h0);
        end
        m_ready = 1'b0;

        // frame counter wrap at FRAME_W=2
        for (int i = 0; i < 5; i++) begin
            full_frame(1'b0, 0);
            check_val("wrap_seq", 32'(frame_cnt), wrap_exp[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lgn_frame_loader.md
# lgn_frame_loader

Host-side driver for the logic-gate-network inference pin interface: takes a byte stream of packed binarized pixels over a valid/ready handshake and replays it onto the 8-bit pixel bus with an active-low write strobe. It waits a fixed settle latency after the last word, captures the 16-bit class-score word and presents it on a valid/ready result port. It sits in the test harness or companion FPGA, at the far end of the chip's pixel-input / score-output pads.

## Interface
- `WORDS`, default 98 — bus words per frame (784 pixels / 8); must be ≥ 2.
- `BUS_W`, default 8 — pixel bus width.
- `OUT_W`, default 16 — result width.
- `LATENCY`, default 4 — cycles between the last write cycle and result capture; range 0–255.
- `FRAME_W`, default 16 — width of the completed-frame counter.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `flush`  in  1  synchronous abort of the current frame.
- `s_valid`  in  1  pixel word offered.
- `s_ready`  out  1  loader accepts a pixel word.
- `s_data`  in  BUS_W  pixel word; bit i is pixel 8·k+i of word k.
- `pix_out`  out  BUS_W  pixel bus to the chip, registered.
- `we_n`  out  1  active-low write strobe to the chip, registered.
- `res_in`  in  OUT_W  score word from the chip.
- `m_valid`  out  1  result available.
- `m_ready`  in  1  result consumer ready.
- `m_data`  out  OUT_W  captured result.
- `busy`  out  1  frame in progress.
- `frame_cnt`  out  FRAME_W  number of completed result handshakes; wraps modulo 2^FRAME_W.

## Operation
- States:
  - LOAD: `s_ready`=1.
  - SETTLE: waiting out `LATENCY`.
  - RESULT: `m_valid`=1.
- Reset state: LOAD.
- `s_ready` is a combinational decode of the state: high only in LOAD, and not gated by `flush`.
- Accept happens on an edge where LOAD && `s_valid` && !`flush`. On accept:
  - `pix_out` ← `s_data`, `we_n` ← 0, `word_cnt`++.
- On every non-accept edge, `we_n` ← 1 and `pix_out` holds its value.
- Result: exactly one low `we_n` cycle per accepted word. Gaps in `s_valid` produce idle cycles with `we_n`=1.
- When the accept edge is the one for word `WORDS`-1:
  - state → SETTLE;
  - `word_cnt` → 0;
  - settle counter ← `LATENCY`.
- SETTLE: the counter decrements each edge. The edge where it reads 0 captures `res_in` into `m_data` and moves to RESULT.
- RESULT: on `m_valid` && `m_ready`:
  - state → LOAD;
  - `frame_cnt`++;
  - `m_data` holds its value until the next capture.
- `flush` has priority over everything except reset, in any state. On a `flush` edge:
  - state → LOAD;
  - `word_cnt` → 0;
  - `we_n` → 1;
  - `m_valid` → 0;
  - `m_data` and `frame_cnt` are unchanged;
  - a simultaneous accept or result handshake is discarded.
- `busy` = (state ≠ LOAD) || (`word_cnt` ≠ 0).
- `word_cnt` is 7 bits minimum (clog2(`WORDS`)).
- The settle counter is 8 bits.
- `frame_cnt` wraps without saturation.

## Timing
- Reset values:
  - `pix_out`=0, `we_n`=1, `m_valid`=0, `m_data`=0, `frame_cnt`=0, `busy`=0;
  - `s_ready`=1 (LOAD).
- Reset mid-frame discards all progress asynchronously. No partial strobe: `we_n` goes to 1 immediately on `rst_n` low.
- Accept at edge t → `pix_out`/`we_n`=0 valid during cycle [t, t+1).
- Last word accepted at edge t_L:
  - `s_ready` is low from t_L;
  - `res_in` is captured at edge t_L+1+`LATENCY`;
  - `m_valid` is high from that edge.
- With `LATENCY`=0, capture is at t_L+1, the edge that ends the last write cycle.
- Result handshake at edge t_H → `s_ready`=1 and `m_valid`=0 from t_H; a new frame can be accepted at t_H+1.
- Maximum throughput: `WORDS`+`LATENCY`+2 cycles per frame with `s_valid` and `m_ready` held high.
- `m_valid` and `m_data` are stable while `m_ready` is low (AXI-stream rules). `s_data` is sampled only on accept.

## Test plan
- **Full frame, streaming.** Stimulus: 98 words, `s_data`=k mod 256, `s_valid` held high; `res_in`=16'hA5C3; `m_ready`=1. Required:
  - exactly 98 `we_n`-low cycles, in order;
  - capture at t_L+5;
  - `m_data`=16'hA5C3;
  - `frame_cnt`=1;
  - `busy` low after the handshake.
- **Input gaps.** Stimulus: `s_valid` toggles every cycle. Required: `we_n` low only on accepted words, `pix_out` holds between them, 98 strobes total, result timing still t_L+5.
- **Result backpressure.** Stimulus: `m_ready`=0 for 20 cycles, `res_in` changing every cycle. Required:
  - `m_data` frozen at the capture value;
  - `s_ready`=0 throughout;
  - release gives the handshake, then `s_ready`=1 and `frame_cnt`++.
- **Flush mid-frame.** Stimulus: `flush` after 40 words, asserted with `s_valid` high. Required:
  - that word is not strobed;
  - `word_cnt`=0, `busy`=0;
  - the next frame needs a full 98 words;
  - `frame_cnt` unchanged.
- **Reset mid-SETTLE.** Stimulus: `rst_n` low during SETTLE. Required: immediate reset values on all outputs and no `m_valid` afterwards.
- **Counter wrap.** Stimulus: `FRAME_W`=2, five frames. Required: `frame_cnt` sequence 1, 2, 3, 0, 1.
